proj1_cpu: RTL and testbench

Accumulator-based 16-bit multicycle processor with a built-in 256x16 RAM. A controller FSM drives a datapath (PC, MAR, MDR, IR, ACC, Z flag) through fetch, decode and execute phases. A 16-bit adder/subtractor and an iterative unsigned divider implement the arithmetic. Memory bus activity is mirrored on output ports for observation. Programs are preloaded into the RAM by the bench; results are read back from RAM.

---
 rtl/proj1_pkg.sv | 36 +++
 rtl/addsub16.sv | 32 +++
 rtl/proj1_ram.sv | 34 +++
 rtl/proj1_cpu.sv | 181 ++++++++++++++++++
 tb/tb_proj1_cpu.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/proj1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proj1_pkg
// Purpose  : Shared definitions for the proj1 accumulator CPU: data/address
//            widths, instruction opcodes and the controller state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package proj1_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_JUMP  = 8'h05;
  localparam logic [7:0] OP_JZ    = 8'h06;
  localparam logic [7:0] OP_DIV   = 8'h07;
  localparam logic [7:0] OP_HALT  = 8'h08;

  typedef enum logic [3:0] {
    ST_F1 = 4'd0,
    ST_F2 = 4'd1,
    ST_F3 = 4'd2,
    ST_D  = 4'd3,
    ST_E1 = 4'd4,
    ST_E2 = 4'd5,
    ST_DV = 4'd6,
    ST_DW = 4'd7,
    ST_H  = 4'd8
  } state_e;

endpackage
`default_nettype wire

// File: rtl/addsub16.sv
`default_nettype none
// ============================================================================
// Module   : addsub16
// Purpose  : 16-bit adder/subtractor shared by ADD/SUB and the divider's
//            trial subtraction.
// Ports    : a, b  - operands
//            sub   - 1 = a - b, 0 = a + b
//            sum   - result modulo 2^16
//            cout  - carry out; for subtraction 1 means no borrow (a >= b)
// Revision : 1.0 - initial release
// ============================================================================
module addsub16
  import proj1_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   full;

  // Two's-complement subtraction: a + ~b + 1.
  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};
  assign sum   = full[DATA_W-1:0];
  assign cout  = full[DATA_W];

endmodule
`default_nettype wire

// File: rtl/proj1_ram.sv
`default_nettype none
// ============================================================================
// Module   : proj1_ram
// Purpose  : 256x16 program/data RAM, combinational read, synchronous write.
//            Contents are not affected by reset.
// Ports    : clk   - clock
//            we    - write enable
//            addr  - read/write address
//            wdata - write data
//            rdata - read data (mem[addr])
// Revision : 1.0 - initial release
// ============================================================================
module proj1_ram
  import proj1_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem256x16 [0:255];

  always_ff @(posedge clk) begin
    if (we) begin
      mem256x16[addr] <= wdata;
    end
  end

  assign rdata = mem256x16[addr];

endmodule
`default_nettype wire

// File: rtl/proj1_cpu.sv
`default_nettype none
// ============================================================================
// Module   : proj1_cpu
// Purpose  : Accumulator-based 16-bit multicycle CPU with internal 256x16 RAM.
//            Controller FSM sequences fetch/decode/execute over PC, MAR, MDR,
//            IR, ACC and Z; DIV uses a 16-step restoring divider.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-low reset
//            MemRW_IO   - RAM write enable this cycle
//            MemAddr_IO - RAM address (MAR)
//            MemD_IO    - RAM write data (ACC)
// Revision : 1.0 - initial release
// ============================================================================
module proj1_cpu
  import proj1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              MemRW_IO,
  output logic [ADDR_W-1:0] MemAddr_IO,
  output logic [DATA_W-1:0] MemD_IO
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d, ir_q, ir_d, acc_q, acc_d;
  logic              z_q, z_d;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [3:0]        cnt_q, cnt_d;

  logic [7:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;

  logic [DATA_W-1:0] div_shift;
  logic [DATA_W-1:0] as_a, as_sum;
  logic              as_sub, as_cout, qbit;

  assign opcode  = ir_q[15:8];
  assign operand = ir_q[7:0];

  // Write is decoded from registered state, so an asynchronous reset drops
  // it immediately and the pending RAM write never gets clocked.
  assign mem_we = (state_q == ST_E1) && (opcode == OP_STORE);

  proj1_ram ram_ins (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mar_q),
    .wdata (acc_q),
    .rdata (mem_rdata)
  );

  // Partial remainder shifted left with the next dividend bit. Its dropped
  // MSB (rem_q[15]) means the 17-bit trial value exceeds any 16-bit divisor,
  // so the subtraction must succeed even though the adder sees 16 bits.
  assign div_shift = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
  assign as_a      = (state_q == ST_DV) ? div_shift : acc_q;
  assign as_sub    = (state_q == ST_DV) || (opcode == OP_SUB);
  assign qbit      = rem_q[DATA_W-1] | as_cout;

  addsub16 u_addsub (
    .a    (as_a),
    .b    (mdr_q),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    z_d     = z_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_F1: begin
        mar_d   = pc_q;
        state_d = ST_F2;
      end
      ST_F2: begin
        mdr_d   = mem_rdata;
        pc_d    = pc_q + 8'd1;
        state_d = ST_F3;
      end
      ST_F3: begin
        ir_d    = mdr_q;
        state_d = ST_D;
      end
      ST_D: begin
        mar_d = operand;
        case (opcode)
          OP_JUMP: begin
            pc_d    = operand;
            state_d = ST_F1;
          end
          OP_JZ: begin
            if (z_q) pc_d = operand;
            state_d = ST_F1;
          end
          OP_HALT:                                   state_d = ST_H;
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_DIV: state_d = ST_E1;
          default:                                   state_d = ST_F1;
        endcase
      end
      ST_E1: begin
        if (opcode == OP_STORE) begin
          state_d = ST_F1;
        end else begin
          mdr_d   = mem_rdata;
          state_d = ST_E2;
        end
      end
      ST_E2: begin
        if (opcode == OP_DIV) begin
          rem_d   = '0;
          quo_d   = acc_q;
          cnt_d   = 4'd0;
          state_d = ST_DV;
        end else begin
          acc_d   = (opcode == OP_LOAD) ? mdr_q : as_sum;
          z_d     = (acc_d == '0);
          state_d = ST_F1;
        end
      end
      ST_DV: begin
        // Divisor 0 makes every trial succeed, giving the 0xFFFF quotient.
        rem_d = qbit ? as_sum : div_shift;
        quo_d = {quo_q[DATA_W-2:0], qbit};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = ST_DW;
      end
      ST_DW: begin
        acc_d   = quo_q;
        z_d     = (quo_q == '0);
        state_d = ST_F1;
      end
      ST_H:    state_d = ST_H;
      default: state_d = ST_F1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_F1;
      pc_q    <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      z_q     <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign MemRW_IO   = mem_we;
  assign MemAddr_IO = mar_q;
  assign MemD_IO    = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_proj1_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_proj1_cpu
// Purpose  : Self-checking bench for proj1_cpu. An instruction-level model
//            predicts every RAM write (address, data, cycle) into a queue
//            that a bus monitor drains; final ACC/Z/PC/RAM and halt state are
//            checked per program. Directed programs plus random ones.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proj1_cpu;
  import proj1_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRW_IO;
  logic [7:0]  MemAddr_IO;
  logic [15:0] MemD_IO;

  proj1_cpu dut (
    .clk        (clk),
    .rst        (rst),
    .MemRW_IO   (MemRW_IO),
    .MemAddr_IO (MemAddr_IO),
    .MemD_IO    (MemD_IO)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  bit mon_en  = 1'b0;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] img[256];
  logic [15:0] ref_mem[256];

  // Cycle index since reset release; cycle 0 is the first F1.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor: every observed write must match the head of the queue.
  always @(negedge clk) begin
    if (rst && mon_en && MemRW_IO) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h at cycle %0d, none expected",
                 MemAddr_IO, MemD_IO, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("store_addr",  {24'd0, MemAddr_IO}, {24'd0, e.addr});
        check("store_data",  {16'd0, MemD_IO},    {16'd0, e.data});
        check("store_cycle", cyc,                 e.cyc);
      end
    end
  end

  function automatic logic [15:0] ins(logic [7:0] op, logic [7:0] a);
    return {op, a};
  endfunction

  // Instruction-level reference: executes the program, timing each
  // instruction by its cycle count; records RAM writes with E1 cycle.
  task automatic ref_run(output bit halted, output int halt_cyc,
                         output logic [15:0] r_acc, output bit r_z,
                         output logic [7:0] r_pc);
    logic [7:0]  pc  = 8'd0;
    logic [15:0] acc = 16'd0;
    logic [15:0] ir, m;
    logic [7:0]  op, a;
    bit          z = 1'b0;
    int          t = 0;
    int          steps = 0;
    halted   = 1'b0;
    halt_cyc = 0;
    while (!halted && steps < 5000) begin
      steps++;
      ir = ref_mem[pc];
      op = ir[15:8];
      a  = ir[7:0];
      pc = pc + 8'd1;
      m  = ref_mem[a];
      case (op)
        8'h01: begin acc = m;       z = (acc == 0); t += 6; end
        8'h02: begin
          exp_q.push_back('{addr: a, data: acc, cyc: t + 4});
          ref_mem[a] = acc;
          t += 5;
        end
        8'h03: begin acc = acc + m; z = (acc == 0); t += 6; end
        8'h04: begin acc = acc - m; z = (acc == 0); t += 6; end
        8'h05: begin pc = a; t += 4; end
        8'h06: begin if (z) pc = a; t += 4; end
        8'h07: begin
          acc = (m == 0) ? 16'hFFFF : acc / m;
          z   = (acc == 0);
          t  += 23;
        end
        8'h08: begin halted = 1'b1; halt_cyc = t + 4; end
        default: t += 4;
      endcase
    end
    r_acc = acc;
    r_z   = z;
    r_pc  = pc;
  endtask

  task automatic load_dut();
    for (int i = 0; i < 256; i++) begin
      dut.ram_ins.mem256x16[i] = img[i];
      ref_mem[i] = img[i];
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 16'h0000;
  endtask

  task automatic run_prog(string name);
    bit          halted;
    int          hc;
    logic [15:0] r_acc;
    bit          r_z;
    logic [7:0]  r_pc;
    int          bad;
    int          first_bad;
    rst    = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
    load_dut();
    exp_q.delete();
    ref_run(halted, hc, r_acc, r_z, r_pc);
    if (!halted) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_model: program does not halt", name);
      return;
    end
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (hc + 6) @(negedge clk);
    check({name, "_pending_stores"}, exp_q.size(), 0);
    check({name, "_halt_state"}, {28'd0, dut.state_q}, {28'd0, ST_H});
    check({name, "_acc"}, {16'd0, dut.acc_q}, {16'd0, r_acc});
    check({name, "_z"},   {31'd0, dut.z_q},   {31'd0, r_z});
    check({name, "_pc"},  {24'd0, dut.pc_q},  {24'd0, r_pc});
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < 256; i++) begin
      if (dut.ram_ins.mem256x16[i] !== ref_mem[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    check({name, "_ram_mismatch_words"}, bad, 0);
    if (bad != 0) $display("  first differing RAM word at 0x%0h", first_bad);
    mon_en = 1'b0;
  endtask

  task automatic gen_random();
    int          len, tgt, r;
    logic [7:0]  nops[4];
    nops[0] = 8'h00; nops[1] = 8'h09; nops[2] = 8'h42; nops[3] = 8'hFF;
    clear_img();
    len = $urandom_range(6, 24);
    for (int i = 0; i < 16; i++) begin
      img[8'h80 + i] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3))
                                                   : 16'($urandom);
    end
    for (int i = 0; i < len - 1; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1, 11: img[i] = ins(8'h01, 8'(8'h80 + $urandom_range(0, 15)));
        2:        img[i] = ins(8'h02, 8'(8'h80 + $urandom_range(0, 15)));
        3, 10:    img[i] = ins(8'h03, 8'(8'h80 + $urandom_range(0, 15)));
        4:        img[i] = ins(8'h04, 8'(8'h80 + $urandom_range(0, 15)));
        5, 6: begin
          // Forward-only branches keep every random program terminating.
          tgt = i + 1 + $urandom_range(0, 3);
          if (tgt > len - 1) tgt = len - 1;
          img[i] = ins((r == 5) ? 8'h05 : 8'h06, 8'(tgt));
        end
        7, 8:     img[i] = ins(8'h07, 8'(8'h80 + $urandom_range(0, 15)));
        default:  img[i] = ins(nops[$urandom_range(0, 3)], 8'($urandom));
      endcase
    end
    img[len - 1] = ins(8'h08, 8'h00);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_memrw",   {31'd0, MemRW_IO},   32'd0);
    check("reset_memaddr", {24'd0, MemAddr_IO}, 32'd0);
    check("reset_memd",    {16'd0, MemD_IO},    32'd0);
    check("reset_state",   {28'd0, dut.state_q}, {28'd0, ST_F1});

    // Add and store.
    clear_img();
    img[0] = ins(8'h01, 8'h10); img[1] = ins(8'h03, 8'h11);
    img[2] = ins(8'h02, 8'h0E); img[3] = ins(8'h08, 8'h00);
    img[8'h10] = 16'h0005; img[8'h11] = 16'h0007;
    run_prog("add_store");
    check("add_store_result", {16'd0, dut.ram_ins.mem256x16[8'h0E]}, 32'h000C);

    // Subtract to zero (JZ must skip the STORE to 0x0D), then wrap.
    clear_img();
    img[0] = ins(8'h01, 8'h10); img[1] = ins(8'h04, 8'h10);
    img[2] = ins(8'h06, 8'h04); img[3] = ins(8'h02, 8'h0D);
    img[4] = ins(8'h04, 8'h11); img[5] = ins(8'h02, 8'h0F);
    img[6] = ins(8'h08, 8'h00);
    img[8'h10] = 16'h1234; img[8'h11] = 16'h0001; img[8'h0D] = 16'hAAAA;
    run_prog("sub_wrap");
    check("sub_zero_jz_taken", {16'd0, dut.ram_ins.mem256x16[8'h0D]}, 32'hAAAA);
    check("sub_wrap_result",   {16'd0, dut.ram_ins.mem256x16[8'h0F]}, 32'hFFFF);
    check("sub_wrap_z",        {31'd0, dut.z_q}, 32'd0);

    // Count down 3 to 0.
    clear_img();
    img[0] = ins(8'h01, 8'h10); img[1] = ins(8'h04, 8'h11);
    img[2] = ins(8'h06, 8'h04); img[3] = ins(8'h05, 8'h01);
    img[4] = ins(8'h02, 8'h0E); img[5] = ins(8'h08, 8'h00);
    img[8'h10] = 16'h0003; img[8'h11] = 16'h0001; img[8'h0E] = 16'h5555;
    run_prog("jz_loop");
    check("jz_loop_result", {16'd0, dut.ram_ins.mem256x16[8'h0E]}, 32'h0000);

    // Divide 100/7 and divide by zero.
    clear_img();
    img[0] = ins(8'h01, 8'h10); img[1] = ins(8'h07, 8'h11);
    img[2] = ins(8'h02, 8'h0E); img[3] = ins(8'h08, 8'h00);
    img[8'h10] = 16'd100; img[8'h11] = 16'd7;
    run_prog("div");
    check("div_result", {16'd0, dut.ram_ins.mem256x16[8'h0E]}, 32'd14);
    img[8'h11] = 16'd0;
    run_prog("div0");
    check("div0_result", {16'd0, dut.ram_ins.mem256x16[8'h0E]}, 32'hFFFF);

    // Reset during the E1 of a STORE (instruction at cycle 6, E1 at 10).
    clear_img();
    img[0] = ins(8'h01, 8'h10); img[1] = ins(8'h02, 8'h0E);
    img[2] = ins(8'h08, 8'h00);
    img[8'h10] = 16'h0BEE; img[8'h0E] = 16'h1111;
    rst = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
    load_dut();
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("rstmid_write_pending", {31'd0, MemRW_IO}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rstmid_memrw",   {31'd0, MemRW_IO},   32'd0);
    check("rstmid_memaddr", {24'd0, MemAddr_IO}, 32'd0);
    check("rstmid_memd",    {16'd0, MemD_IO},    32'd0);
    check("rstmid_pc",      {24'd0, dut.pc_q},   32'd0);
    check("rstmid_acc",     {16'd0, dut.acc_q},  32'd0);
    @(posedge clk);
    #1;
    check("rstmid_ram_unchanged", {16'd0, dut.ram_ins.mem256x16[8'h0E]}, 32'h1111);
    run_prog("rst_restart");
    check("rst_restart_result", {16'd0, dut.ram_ins.mem256x16[8'h0E]}, 32'h0BEE);

    // Random programs.
    for (int k = 0; k < 30; k++) begin
      gen_random();
      run_prog($sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
